// File: rtl/decompressed_row_writer_pkg.sv
// Shared definitions for the decompressed row writer: state encoding and default region bases.
// The IO controller decodes the same state values.
package decompressed_row_writer_pkg;

  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_LOAD  = 2'd1;
  localparam logic [1:0] STATE_DRAIN = 2'd2;
  localparam logic [1:0] STATE_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = STATE_IDLE,
    ST_LOAD  = STATE_LOAD,
    ST_DRAIN = STATE_DRAIN,
    ST_DONE  = STATE_DONE
  } state_e;

  localparam logic [15:0] CNN_BASE_DEFAULT = 16'h0000;
  localparam logic [15:0] IMG_BASE_DEFAULT = 16'h8000;

endpackage

// File: rtl/decompressed_row_writer_row_fifo.sv
// Synchronous row FIFO with flush; full/empty/count come straight from registered state.
module row_fifo #(
  parameter int ROW_SIZE   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic                          flush,
  input  logic [ROW_SIZE-1:0]           din,
  output logic [ROW_SIZE-1:0]           head,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(FIFO_DEPTH);

  logic [ROW_SIZE-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PW:0]         count_q, count_d;
  logic                do_push, do_pop;

  // A push is refused whenever the FIFO is full, even if a pop happens the same cycle.
  assign do_push = push && (count_q != DEPTH_C) && !flush;
  assign do_pop  = pop && (count_q != '0) && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/decompressed_row_writer.sv
// Writes decompressed rows to the CNN-weight or image region of on-chip memory through a row FIFO.
// Optional ROW_WRITER_CHECKSUM_EN adds an XOR checksum of all written rows.
module decompressed_row_writer
  import decompressed_row_writer_pkg::*;
#(
  parameter int                    ROW_SIZE   = 16,
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] CNN_BASE   = ADDR_WIDTH'(CNN_BASE_DEFAULT),
  parameter logic [ADDR_WIDTH-1:0] IMG_BASE   = ADDR_WIDTH'(IMG_BASE_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  cnn_img,
  input  logic [ADDR_WIDTH-1:0] num_rows,
  input  logic                  interrupt,
  input  logic                  row_valid,
  input  logic [ROW_SIZE-1:0]   row_data,
  output logic                  row_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [ROW_SIZE-1:0]   mem_wdata,
  input  logic                  mem_ack,
  output logic                  busy,
  output logic                  done
`ifdef ROW_WRITER_CHECKSUM_EN
  ,
  output logic [ROW_SIZE-1:0]   checksum
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] target_q, target_d;
  logic [ADDR_WIDTH-1:0] accepted_q, accepted_d;

  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [ROW_SIZE-1:0]   fifo_head;
  logic                  active, accept, write_done, flush;

  assign active     = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign row_ready  = (state_q == ST_LOAD) && !fifo_full;
  assign mem_we     = active && !fifo_empty;
  // interrupt outranks everything: no push, pop or address step on that cycle
  assign accept     = row_valid && row_ready && !interrupt;
  assign write_done = mem_we && mem_ack && !interrupt;
  assign flush      = interrupt && active;

  row_fifo #(
    .ROW_SIZE  (ROW_SIZE),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_row_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (accept),
    .pop  (write_done),
    .flush(flush),
    .din  (row_data),
    .head (fifo_head),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    target_d   = target_q;
    accepted_d = accepted_q;
    if (write_done) addr_d = addr_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          target_d   = num_rows;
          accepted_d = '0;
          addr_d     = cnn_img ? CNN_BASE : IMG_BASE;
          state_d    = (num_rows == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (interrupt) begin
          state_d = ST_IDLE;
        end else if (accept) begin
          accepted_d = accepted_q + 1'b1;
          if (accepted_d == target_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // finish as soon as the FIFO is empty after this edge
        if (interrupt) state_d = ST_IDLE;
        else if (fifo_empty || (fifo_count == CW'(1) && write_done)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!load) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      target_q   <= '0;
      accepted_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      target_q   <= target_d;
      accepted_q <= accepted_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = mem_we ? fifo_head : '0;
  assign busy      = active;
  assign done      = (state_q == ST_DONE);

`ifdef ROW_WRITER_CHECKSUM_EN
  logic [ROW_SIZE-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (state_q == ST_IDLE && load) checksum_d = '0;
    else if (write_done)            checksum_d = checksum_q ^ fifo_head;
  end

  always_ff @(posedge clk) begin
    if (rst) checksum_q <= '0;
    else     checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`endif

endmodule
